// File: rtl/rv_decode_stage_pkg.sv
// Shared types for the RV32I decode stage: op/format enums, opcodes, the queued
// entry layout, and the combinational decoder.
package rv_decode_stage_pkg;

    // Entries carry the widest supported XLEN; the top trims to its own XLEN.
    localparam int IMM_W = 64;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [5:0] {
        OP_NOP, OP_UNKNOWN,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK
    } t_risc_v_op;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} t_imm_fmt;

    typedef struct packed {
        t_risc_v_op       op;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [IMM_W-1:0] imm;
        t_imm_fmt         fmt;
        logic [IMM_W-1:0] pc;
        logic             illegal;
    } t_dec_entry;

    function automatic t_dec_entry decode_rv32i(input logic [31:0] ins);
        t_dec_entry d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3    = ins[14:12];
        f7    = ins[31:25];
        d     = '0;
        d.op  = OP_UNKNOWN;
        d.rd  = ins[11:7];
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        case (ins[6:0])
            OPC_LUI:   begin d.op = OP_LUI;   d.fmt = FMT_U; end
            OPC_AUIPC: begin d.op = OP_AUIPC; d.fmt = FMT_U; end
            OPC_JAL:   begin d.op = OP_JAL;   d.fmt = FMT_J; end
            OPC_JALR:  begin d.fmt = FMT_I; if (f3 == 3'b000) d.op = OP_JALR; end
            OPC_BRANCH: begin
                d.fmt = FMT_B;
                case (f3)
                    3'b000: d.op = OP_BEQ;
                    3'b001: d.op = OP_BNE;
                    3'b100: d.op = OP_BLT;
                    3'b101: d.op = OP_BGE;
                    3'b110: d.op = OP_BLTU;
                    3'b111: d.op = OP_BGEU;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                d.fmt = FMT_I;
                case (f3)
                    3'b000: d.op = OP_LB;
                    3'b001: d.op = OP_LH;
                    3'b010: d.op = OP_LW;
                    3'b100: d.op = OP_LBU;
                    3'b101: d.op = OP_LHU;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                d.fmt = FMT_S;
                case (f3)
                    3'b000: d.op = OP_SB;
                    3'b001: d.op = OP_SH;
                    3'b010: d.op = OP_SW;
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                d.fmt = FMT_I;
                case (f3)
                    3'b000: d.op = OP_ADDI;
                    3'b010: d.op = OP_SLTI;
                    3'b011: d.op = OP_SLTIU;
                    3'b100: d.op = OP_XORI;
                    3'b110: d.op = OP_ORI;
                    3'b111: d.op = OP_ANDI;
                    3'b001: if (f7 == F7_BASE) d.op = OP_SLLI;
                    3'b101: begin
                        if (f7 == F7_BASE)     d.op = OP_SRLI;
                        else if (f7 == F7_ALT) d.op = OP_SRAI;
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                d.fmt = FMT_R;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000: d.op = OP_ADD;
                        3'b001: d.op = OP_SLL;
                        3'b010: d.op = OP_SLT;
                        3'b011: d.op = OP_SLTU;
                        3'b100: d.op = OP_XOR;
                        3'b101: d.op = OP_SRL;
                        3'b110: d.op = OP_OR;
                        default: d.op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      d.op = OP_SUB;
                    else if (f3 == 3'b101) d.op = OP_SRA;
                end
            end
            OPC_MISC_MEM: begin d.fmt = FMT_I; if (f3 == 3'b000) d.op = OP_FENCE; end
            OPC_SYSTEM: begin
                d.fmt = FMT_I;
                if (ins == 32'h0000_0073)      d.op = OP_ECALL;
                else if (ins == 32'h0010_0073) d.op = OP_EBREAK;
            end
            default: ;
        endcase
        // Anything unrecognised collapses to an R-shaped entry with no immediate.
        if (d.op == OP_UNKNOWN) d.fmt = FMT_R;
        d.illegal = (d.op == OP_UNKNOWN);
        case (d.fmt)
            FMT_I: d.imm = {{52{ins[31]}}, ins[31:20]};
            FMT_S: d.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B: d.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U: d.imm = {{32{ins[31]}}, ins[31:12], 12'b0};
            FMT_J: d.imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: d.imm = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side signals of the decode stage, bundled for port use.
interface rv_decode_stage_if
    import rv_decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // Both sides use plain valid/ready: a beat transfers on any edge where valid
    // and ready are both high; valid never waits on ready, payload holds while
    // valid is high and ready is low.
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_instr_i;
    logic [XLEN-1:0]  in_pc_i;
    logic             out_valid_o;
    logic             out_ready_i;
    t_risc_v_op       op_o;
    logic [4:0]       rd_o;
    logic [4:0]       rs1_o;
    logic [4:0]       rs2_o;
    logic [XLEN-1:0]  imm_o;
    t_imm_fmt         imm_fmt_o;
    logic [XLEN-1:0]  pc_o;
    logic             illegal_o;
    logic [CNT_W-1:0] illegal_cnt_o;

    modport master (
        output flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, op_o, rd_o, rs1_o, rs2_o, imm_o, imm_fmt_o,
               pc_o, illegal_o, illegal_cnt_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, op_o, rd_o, rs1_o, rs2_o, imm_o, imm_fmt_o,
               pc_o, illegal_o, illegal_cnt_o
    );
endinterface

// File: rtl/rv_decode_stage_fifo.sv
// Synchronous FIFO holding decoded entries; flush and reset both empty it.
module decode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= wdata_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_i) rd_ptr <= rd_ptr + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_o <= count_o + CW'(1);
                2'b01:   count_o <= count_o - CW'(1);
                default: ;
            endcase
        end
    end

    assign rdata_o = mem[rd_ptr];
endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: decodes each accepted fetch word and queues the result
// for execute, with backpressure, flush and an illegal-instruction counter.
module rv_decode_stage
    import rv_decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int SWAP_BYTES = 1,
    parameter int CNT_W      = 16
) (
    input logic         clk_i,
    input logic         rst_i,
    rv_decode_stage_if.slave bus
);
    localparam int EW = $bits(t_dec_entry);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]      instr;
    t_dec_entry       dec;
    t_dec_entry       head;
    logic [EW-1:0]    fifo_rdata;
    logic [CW-1:0]    count;
    logic             out_valid;
    logic             in_ready;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] ill_cnt;

    assign instr = (SWAP_BYTES != 0)
        ? {bus.in_instr_i[7:0], bus.in_instr_i[15:8], bus.in_instr_i[23:16], bus.in_instr_i[31:24]}
        : bus.in_instr_i;

    always_comb begin
        dec    = decode_rv32i(instr);
        dec.pc = IMM_W'(bus.in_pc_i);
    end

    // A full queue still accepts when its head leaves in the same cycle.
    assign out_valid = (count != '0);
    assign pop       = out_valid && bus.out_ready_i;
    assign in_ready  = (count < CW'(DEPTH)) || pop;
    assign push      = bus.in_valid_i && in_ready && !bus.flush_i;

    decode_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bus.flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (dec),
        .rdata_o (fifo_rdata),
        .count_o (count)
    );

    always_comb begin
        head = '0;
        if (out_valid) head = t_dec_entry'(fifo_rdata);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ill_cnt <= '0;
        end else if (push && dec.illegal && (ill_cnt != '1)) begin
            ill_cnt <= ill_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready_o    = in_ready;
    assign bus.out_valid_o   = out_valid;
    assign bus.op_o          = head.op;
    assign bus.rd_o          = head.rd;
    assign bus.rs1_o         = head.rs1;
    assign bus.rs2_o         = head.rs2;
    assign bus.imm_o         = head.imm[XLEN-1:0];
    assign bus.imm_fmt_o     = head.fmt;
    assign bus.pc_o          = head.pc[XLEN-1:0];
    assign bus.illegal_o     = head.illegal;
    assign bus.illegal_cnt_o = ill_cnt;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: two instances (raw/32-bit and byte-swapped/64-bit,
// 2-bit counter) share stimulus and are checked every cycle against a table model.
module tb_rv_decode_stage;
    import rv_decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;
    logic        out_ready = 1'b0;
    logic        started = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: accepted words in order as {pc, word}, plus the two counters.
    logic [95:0] exp_q[$];
    int          cnt_a = 0;
    int          cnt_b = 0;

    // Instruction table in mask/match form, first hit wins.
    logic [31:0] tab_mask [64];
    logic [31:0] tab_match[64];
    t_risc_v_op  tab_op   [64];
    t_imm_fmt    tab_fmt  [64];
    int          n_tab = 0;

    always #5 clk = ~clk;

    rv_decode_stage_if #(.XLEN(32), .CNT_W(16)) ifa ();
    rv_decode_stage_if #(.XLEN(64), .CNT_W(2))  ifb ();

    assign ifa.flush_i = flush;      assign ifb.flush_i = flush;
    assign ifa.in_valid_i = in_valid; assign ifb.in_valid_i = in_valid;
    assign ifa.in_instr_i = instr;   assign ifb.in_instr_i = instr;
    assign ifa.in_pc_i = pc[31:0];   assign ifb.in_pc_i = pc;
    assign ifa.out_ready_i = out_ready; assign ifb.out_ready_i = out_ready;

    rv_decode_stage #(.XLEN(32), .DEPTH(2), .SWAP_BYTES(0), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa.slave));
    rv_decode_stage #(.XLEN(64), .DEPTH(2), .SWAP_BYTES(1), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb.slave));

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic tab_add(input logic [31:0] m, input logic [31:0] k, input t_risc_v_op op,
                           input t_imm_fmt f);
        tab_mask[n_tab] = m; tab_match[n_tab] = k; tab_op[n_tab] = op; tab_fmt[n_tab] = f;
        n_tab++;
    endtask

    task automatic fill_table();
        tab_add(32'h7F, 32'h37, OP_LUI, FMT_U);     tab_add(32'h7F, 32'h17, OP_AUIPC, FMT_U);
        tab_add(32'h7F, 32'h6F, OP_JAL, FMT_J);     tab_add(32'h707F, 32'h67, OP_JALR, FMT_I);
        tab_add(32'h707F, 32'h0063, OP_BEQ, FMT_B); tab_add(32'h707F, 32'h1063, OP_BNE, FMT_B);
        tab_add(32'h707F, 32'h4063, OP_BLT, FMT_B); tab_add(32'h707F, 32'h5063, OP_BGE, FMT_B);
        tab_add(32'h707F, 32'h6063, OP_BLTU, FMT_B); tab_add(32'h707F, 32'h7063, OP_BGEU, FMT_B);
        tab_add(32'h707F, 32'h0003, OP_LB, FMT_I);  tab_add(32'h707F, 32'h1003, OP_LH, FMT_I);
        tab_add(32'h707F, 32'h2003, OP_LW, FMT_I);  tab_add(32'h707F, 32'h4003, OP_LBU, FMT_I);
        tab_add(32'h707F, 32'h5003, OP_LHU, FMT_I); tab_add(32'h707F, 32'h0023, OP_SB, FMT_S);
        tab_add(32'h707F, 32'h1023, OP_SH, FMT_S);  tab_add(32'h707F, 32'h2023, OP_SW, FMT_S);
        tab_add(32'h707F, 32'h0013, OP_ADDI, FMT_I); tab_add(32'h707F, 32'h2013, OP_SLTI, FMT_I);
        tab_add(32'h707F, 32'h3013, OP_SLTIU, FMT_I); tab_add(32'h707F, 32'h4013, OP_XORI, FMT_I);
        tab_add(32'h707F, 32'h6013, OP_ORI, FMT_I); tab_add(32'h707F, 32'h7013, OP_ANDI, FMT_I);
        tab_add(32'hFE00707F, 32'h1013, OP_SLLI, FMT_I);
        tab_add(32'hFE00707F, 32'h5013, OP_SRLI, FMT_I);
        tab_add(32'hFE00707F, 32'h40005013, OP_SRAI, FMT_I);
        tab_add(32'hFE00707F, 32'h0033, OP_ADD, FMT_R); tab_add(32'hFE00707F, 32'h40000033, OP_SUB, FMT_R);
        tab_add(32'hFE00707F, 32'h1033, OP_SLL, FMT_R); tab_add(32'hFE00707F, 32'h2033, OP_SLT, FMT_R);
        tab_add(32'hFE00707F, 32'h3033, OP_SLTU, FMT_R); tab_add(32'hFE00707F, 32'h4033, OP_XOR, FMT_R);
        tab_add(32'hFE00707F, 32'h5033, OP_SRL, FMT_R); tab_add(32'hFE00707F, 32'h40005033, OP_SRA, FMT_R);
        tab_add(32'hFE00707F, 32'h6033, OP_OR, FMT_R);  tab_add(32'hFE00707F, 32'h7033, OP_AND, FMT_R);
        tab_add(32'h707F, 32'h000F, OP_FENCE, FMT_I);
        tab_add(32'hFFFFFFFF, 32'h00000073, OP_ECALL, FMT_I);
        tab_add(32'hFFFFFFFF, 32'h00100073, OP_EBREAK, FMT_I);
    endtask

    // Immediates built with signed arithmetic on the whole word.
    task automatic model_decode(input logic [31:0] w, output t_risc_v_op op, output t_imm_fmt fmt,
                                output logic [63:0] imm);
        int s;
        int v;
        s   = int'(w);
        op  = OP_UNKNOWN;
        fmt = FMT_R;
        for (int i = 0; i < n_tab; i++) begin
            if (op == OP_UNKNOWN && (w & tab_mask[i]) == tab_match[i]) begin
                op = tab_op[i]; fmt = tab_fmt[i];
            end
        end
        case (fmt)
            FMT_I: v = s >>> 20;
            FMT_S: v = ((s >>> 25) <<< 5) | int'(w[11:7]);
            FMT_B: v = ((s >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
            FMT_U: v = int'(w & 32'hFFFFF000);
            FMT_J: v = ((s >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
            default: v = 0;
        endcase
        imm = 64'(longint'(v));
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_side(input string tag, input logic have, input logic [31:0] w_in,
                              input logic [63:0] pc_in, input logic [63:0] xm,
                              input logic [63:0] op, input logic [63:0] rd, input logic [63:0] rs1,
                              input logic [63:0] rs2, input logic [63:0] imm, input logic [63:0] fmt,
                              input logic [63:0] apc, input logic [63:0] ill);
        t_risc_v_op  eop;
        t_imm_fmt    efmt;
        logic [63:0] eimm;
        logic [31:0] w;
        logic [63:0] epc;
        w = have ? w_in : 32'h0;
        epc = have ? pc_in : 64'h0;
        if (have) model_decode(w, eop, efmt, eimm);
        else begin eop = OP_NOP; efmt = FMT_R; eimm = '0; end
        check({tag, "op"}, op, 64'(eop));
        check({tag, "rd"}, rd, 64'(w[11:7]));
        check({tag, "rs1"}, rs1, 64'(w[19:15]));
        check({tag, "rs2"}, rs2, 64'(w[24:20]));
        check({tag, "imm"}, imm, eimm & xm);
        check({tag, "fmt"}, fmt, 64'(efmt));
        check({tag, "pc"}, apc, epc & xm);
        check({tag, "illegal"}, ill, 64'(have && eop == OP_UNKNOWN));
    endtask

    // Per-cycle compare, then advance the model by what the coming edge does.
    task automatic compare_and_step();
        int          sz;
        logic        have;
        logic        pop;
        logic        accept;
        t_risc_v_op  op_a;
        t_risc_v_op  op_b;
        t_imm_fmt    f;
        logic [63:0] im;
        sz   = exp_q.size();
        have = (sz > 0);
        check("a_out_valid", 64'(ifa.out_valid_o), 64'(have));
        check("b_out_valid", 64'(ifb.out_valid_o), 64'(have));
        check("a_in_ready", 64'(ifa.in_ready_o), 64'(sz < 2 || (have && out_ready)));
        check("b_in_ready", 64'(ifb.in_ready_o), 64'(sz < 2 || (have && out_ready)));
        check_side("a_", have, have ? exp_q[0][31:0] : 32'h0, have ? exp_q[0][95:32] : 64'h0,
                   64'hFFFF_FFFF, 64'(ifa.op_o), 64'(ifa.rd_o), 64'(ifa.rs1_o), 64'(ifa.rs2_o),
                   64'(ifa.imm_o), 64'(ifa.imm_fmt_o), 64'(ifa.pc_o), 64'(ifa.illegal_o));
        check_side("b_", have, have ? swap(exp_q[0][31:0]) : 32'h0, have ? exp_q[0][95:32] : 64'h0,
                   {64{1'b1}}, 64'(ifb.op_o), 64'(ifb.rd_o), 64'(ifb.rs1_o), 64'(ifb.rs2_o),
                   ifb.imm_o, 64'(ifb.imm_fmt_o), ifb.pc_o, 64'(ifb.illegal_o));
        check("a_cnt", 64'(ifa.illegal_cnt_o), 64'(cnt_a));
        check("b_cnt", 64'(ifb.illegal_cnt_o), 64'(cnt_b));
        if (rst) begin
            exp_q.delete(); cnt_a = 0; cnt_b = 0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            pop    = have && out_ready;
            accept = in_valid && (sz < 2 || pop);
            if (pop) void'(exp_q.pop_front());
            if (accept) begin
                exp_q.push_back({pc, instr});
                model_decode(instr, op_a, f, im);
                model_decode(swap(instr), op_b, f, im);
                if (op_a == OP_UNKNOWN && cnt_a < 65535) cnt_a++;
                if (op_b == OP_UNKNOWN && cnt_b < 3) cnt_b++;
            end
        end
    endtask

    always @(negedge clk) if (started) compare_and_step();

    task automatic drive(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
        in_valid = v; instr = w; out_ready = rdy; flush = fl;
        pc = {$urandom(), $urandom()};
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_word();
        int k;
        int i;
        logic [31:0] w;
        k = $urandom_range(0, 9);
        i = $urandom_range(0, n_tab - 1);
        w = ($urandom() & ~tab_mask[i]) | tab_match[i];
        if (k < 4) return w;
        if (k < 8) return swap(w);
        return $urandom();
    endfunction

    initial begin
        t_risc_v_op  mop;
        t_imm_fmt    mfmt;
        logic [63:0] mimm;
        fill_table();
        // Pin the model against hand-decoded encodings.
        model_decode(32'hFE000EE3, mop, mfmt, mimm);
        check("model_beq_op", 64'(mop), 64'(OP_BEQ));
        check("model_beq_imm", mimm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("model_beq_fmt", 64'(mfmt), 64'(FMT_B));
        model_decode(32'h008000EF, mop, mfmt, mimm);
        check("model_jal_imm", mimm, 64'h8);
        model_decode(32'h40001013, mop, mfmt, mimm);
        check("model_bad_slli", 64'(mop), 64'(OP_UNKNOWN));
        model_decode(32'hFE112E23, mop, mfmt, mimm);
        check("model_sw_imm", mimm, 64'hFFFF_FFFF_FFFF_FFFC);

        @(posedge clk); #1;
        started = 1'b1;
        drive(0, 32'h0, 0, 0);
        rst = 1'b0;
        check("rst_a_valid", 64'(ifa.out_valid_o), 64'h0);
        check("rst_a_op", 64'(ifa.op_o), 64'(OP_NOP));
        check("rst_b_cnt", 64'(ifb.illegal_cnt_o), 64'h0);

        drive(1, 32'h93005000, 1, 0);
        check("t1_b_op", 64'(ifb.op_o), 64'(OP_ADDI));
        check("t1_b_rd", 64'(ifb.rd_o), 64'd1);
        check("t1_b_rs1", 64'(ifb.rs1_o), 64'd0);
        check("t1_b_imm", ifb.imm_o, 64'd5);
        check("t1_b_fmt", 64'(ifb.imm_fmt_o), 64'(FMT_I));
        drive(1, 32'hFE000EE3, 1, 0);
        check("t2_a_op", 64'(ifa.op_o), 64'(OP_BEQ));
        check("t2_a_imm", 64'(ifa.imm_o), 64'hFFFF_FFFC);
        check("t2_a_fmt", 64'(ifa.imm_fmt_o), 64'(FMT_B));
        drive(1, 32'h123452B7, 1, 0);
        check("t3_a_op", 64'(ifa.op_o), 64'(OP_LUI));
        check("t3_a_rd", 64'(ifa.rd_o), 64'd5);
        check("t3_a_imm", 64'(ifa.imm_o), 64'h1234_5000);
        drive(1, 32'h008000EF, 1, 0);
        check("t4_a_op", 64'(ifa.op_o), 64'(OP_JAL));
        check("t4_a_rd", 64'(ifa.rd_o), 64'd1);
        check("t4_a_imm", 64'(ifa.imm_o), 64'd8);
        drive(0, 32'h0, 1, 0);

        rst = 1'b1; drive(0, 32'h0, 0, 0); rst = 1'b0;
        drive(1, 32'hFFFFFFFF, 1, 0);
        drive(1, 32'h40001013, 1, 0);
        check("ill_a_op", 64'(ifa.op_o), 64'(OP_UNKNOWN));
        check("ill_a_flag", 64'(ifa.illegal_o), 64'h1);
        check("ill_a_cnt2", 64'(ifa.illegal_cnt_o), 64'd2);
        check("ill_b_cnt2", 64'(ifb.illegal_cnt_o), 64'd2);
        repeat (3) drive(1, 32'hFFFFFFFF, 1, 0);
        check("ill_b_sat", 64'(ifb.illegal_cnt_o), 64'd3);
        check("ill_a_cnt5", 64'(ifa.illegal_cnt_o), 64'd5);
        drive(0, 32'h0, 1, 0);

        drive(1, 32'h00100093, 0, 0);
        drive(1, 32'h00200113, 0, 0);
        check("bp_full_ready", 64'(ifa.in_ready_o), 64'h0);
        drive(1, 32'h00300193, 0, 0);
        check("bp_held_ready", 64'(ifa.in_ready_o), 64'h0);
        check("bp_head_stable", 64'(ifa.rd_o), 64'd1);
        drive(1, 32'h00300193, 1, 0);
        check("bp_release_head", 64'(ifa.rd_o), 64'd2);
        drive(0, 32'h0, 1, 0);
        check("bp_third_head", 64'(ifa.rd_o), 64'd3);
        drive(0, 32'h0, 1, 0);
        check("bp_drained", 64'(ifa.out_valid_o), 64'h0);

        drive(1, 32'h00100093, 0, 0);
        drive(1, 32'h00200113, 0, 0);
        drive(1, 32'hFFFFFFFF, 0, 1);
        check("flush_valid", 64'(ifa.out_valid_o), 64'h0);
        check("flush_cnt", 64'(ifa.illegal_cnt_o), 64'd5);

        drive(1, 32'hFFFFFFFF, 0, 0);
        drive(1, 32'h00200113, 0, 0);
        rst = 1'b1; drive(1, 32'hFFFFFFFF, 0, 0); rst = 1'b0;
        check("mrst_valid", 64'(ifa.out_valid_o), 64'h0);
        check("mrst_op", 64'(ifa.op_o), 64'(OP_NOP));
        check("mrst_cnt", 64'(ifa.illegal_cnt_o), 64'h0);

        repeat (3000) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 49) == 0);
        end
        rst = 1'b0;
        repeat (3) drive(0, 32'h0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
